// File: rtl/fadd_arbiter.sv
// ============================================================================
//  Module   : fadd_arbiter
//  Purpose  : Round-robin sharing of one FADD unit between two requesters,
//             with a one-entry tagged writeback buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fadd_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          Reset,

  input  logic          Req0Valid,
  output logic          Req0Ready,
  input  logic [DW-1:0] Req0Operand1,
  input  logic [DW-1:0] Req0Operand2,
  input  logic [AW-1:0] Req0WA3,

  input  logic          Req1Valid,
  output logic          Req1Ready,
  input  logic [DW-1:0] Req1Operand1,
  input  logic [DW-1:0] Req1Operand2,
  input  logic [AW-1:0] Req1WA3,

  output logic          FaddStart,
  output logic [DW-1:0] FaddOperand1,
  output logic [DW-1:0] FaddOperand2,
  output logic [AW-1:0] FaddWA3,
  input  logic          FaddDone,
  input  logic [DW-1:0] FaddResult,
  input  logic [AW-1:0] FaddRA3,

  output logic          WbValid,
  input  logic          WbReady,
  output logic [DW-1:0] WbResult,
  output logic [AW-1:0] WbWA3,
  output logic          WbId,

  output logic          Busy,
  output logic          Error
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_EXEC = 2'd1;
  localparam logic [1:0] C_GAP  = 2'd2;

  logic [1:0]    state_q,        state_d;
  logic          last_grant_q,   last_grant_d;
  logic          in_flight_id_q, in_flight_id_d;
  logic          wb_valid_q,     wb_valid_d;
  logic [DW-1:0] wb_result_q,    wb_result_d;
  logic [AW-1:0] wb_wa3_q,       wb_wa3_d;
  logic          wb_id_q,        wb_id_d;
  logic          error_q,        error_d;

  logic w_can_issue;
  logic w_grant_id;
  logic w_issue;
  logic w_capture;

  // Reset gates the handshake so nothing is issued while the FADD is held in reset.
  always_comb begin
    w_can_issue = (state_q == C_IDLE) && (!wb_valid_q || WbReady) && !Reset;
    w_grant_id  = (Req0Valid && Req1Valid) ? ~last_grant_q : Req1Valid;
    Req0Ready   = w_can_issue && Req0Valid && !w_grant_id;
    Req1Ready   = w_can_issue && Req1Valid &&  w_grant_id;
    w_issue     = Req0Ready || Req1Ready;
    w_capture   = (state_q == C_EXEC) && FaddDone;
  end

  always_comb begin
    FaddStart    = w_issue;
    FaddOperand1 = '0;
    FaddOperand2 = '0;
    FaddWA3      = '0;
    if (w_issue) begin
      FaddOperand1 = w_grant_id ? Req1Operand1 : Req0Operand1;
      FaddOperand2 = w_grant_id ? Req1Operand2 : Req0Operand2;
      FaddWA3      = w_grant_id ? Req1WA3      : Req0WA3;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    in_flight_id_d = in_flight_id_q;
    error_d        = error_q;
    case (state_q)
      C_IDLE: begin
        if (w_issue) begin
          state_d        = C_EXEC;
          last_grant_d   = w_grant_id;
          in_flight_id_d = w_grant_id;
        end
        if (FaddDone) error_d = 1'b1;
      end
      C_EXEC: begin
        state_d = C_GAP;
        if (!FaddDone) error_d = 1'b1;
      end
      C_GAP: begin
        state_d = C_IDLE;
        if (FaddDone) error_d = 1'b1;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // A capture always takes priority over a drain in the same cycle.
  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_wa3_d    = wb_wa3_q;
    wb_id_d     = wb_id_q;
    if (w_capture) begin
      wb_valid_d  = 1'b1;
      wb_result_d = FaddResult;
      wb_wa3_d    = FaddRA3;
      wb_id_d     = in_flight_id_q;
    end else if (wb_valid_q && WbReady) begin
      wb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q        <= C_IDLE;
      last_grant_q   <= 1'b1;
      in_flight_id_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_result_q    <= '0;
      wb_wa3_q       <= '0;
      wb_id_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      in_flight_id_q <= in_flight_id_d;
      wb_valid_q     <= wb_valid_d;
      wb_result_q    <= wb_result_d;
      wb_wa3_q       <= wb_wa3_d;
      wb_id_q        <= wb_id_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    WbValid  = wb_valid_q;
    WbResult = wb_result_q;
    WbWA3    = wb_wa3_q;
    WbId     = wb_id_q;
    Error    = error_q;
    Busy     = ((state_q != C_IDLE) || wb_valid_q) && !Reset;
  end

endmodule

`default_nettype wire
